ascon_perm: RTL and testbench
=============================

ASCON_PERM -- requirements
Module: ascon_perm

Interface
REQ-001 SHALL have parameter: ROUNDS_PER_CYCLE, default 1, rounds applied per clock; legal values 1 or 2.
REQ-002 SHALL have port: clk_i  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start_i  input  1  request a permutation; sampled only in IDLE.
REQ-005 SHALL have port: rounds_i  input  4  rounds n to apply; sampled with start_i.
REQ-006 SHALL have port: state_i  input  state_t (5x64)  permutation input; sampled with start_i.
REQ-007 SHALL have port: state_o  output  state_t  working/result state register.
REQ-008 SHALL have port: busy_o  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done_o  output  1  one-cycle pulse; state_o holds the final result.
REQ-010 SHALL have port: update_state_o  output  1  equal to done_o; commits the result to the register block.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-012 IDLE with start_i=1 SHALL capture state_i into state_o and n into the remaining-round counter.
- Effective n: n = min(rounds_i, 12).
- Round index: i = 12 - n.
- n = 0 SHALL go to DONE directly, with state_o = state_i.
REQ-013 RUN SHALL apply k = min(ROUNDS_PER_CYCLE, remaining) rounds per cycle, then do i += k and remaining -= k; it SHALL enter DONE when remaining reaches 0.
REQ-014 Each round SHALL perform, in order:
- x2 ^= {56'b0, c_i}, with c_i = 8'hF0 - i*8'h0F;
- 5-bit bitsliced Ascon S-box on every bit column;
- linear layer, rotate-right (ror) amounts:
  - x0: ror 19 and ror 28
  - x1: ror 61 and ror 39
  - x2: ror 1 and ror 6
  - x3: ror 10 and ror 17
  - x4: ror 7 and ror 41
REQ-015 Latency: done_o SHALL be high exactly ceil(n/ROUNDS_PER_CYCLE)+1 cycles after the start cycle (n=0: 1 cycle).
REQ-016 DONE SHALL last exactly one cycle with done_o=update_state_o=1, then return to IDLE.
REQ-017 start_i SHALL be ignored in RUN and DONE; no queuing.
REQ-018 state_o SHALL hold its value in IDLE until the next accepted start.
REQ-019 Changes on rounds_i/state_i after the start cycle SHALL have no effect.

Reset
REQ-020 Asserting rst_n_i low at any time, including mid-RUN, SHALL immediately force:
- FSM to IDLE;
- state_o = 0;
- counters = 0;
- busy_o = done_o = update_state_o = 0;
- intr_o = 0 if present.
REQ-021 The first start SHALL be accepted in the first cycle after reset deassertion.

Configuration
REQ-022 With ASCON_PERM_INTR_EN defined:
- the module SHALL add port intr_o  output  1;
- intr_o SHALL rise with done_o and stay high until the next accepted start_i.
REQ-023 Without ASCON_PERM_INTR_EN, intr_o SHALL not exist, with no other behavioural difference.

Structure
REQ-024 The shared package SHALL hold:
- state_t;
- the round-constant function;
- the S-box and linear-layer functions;
- the maximum-rounds constant 12.
REQ-025 Sub-module ascon_round (combinational, one round: state_t and round index in, state_t out) SHALL be instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-026 All-zero state_i, rounds_i=12, R=1 -> done_o at cycle 13 and state_o equal to the golden software p12 of zero.
REQ-027 Ascon-128 init state (x0=64'h80400C0600000000, key/nonce 0), rounds_i=12, R=1 and R=2 -> identical golden result; done at cycle 13 (R=1) and cycle 7 (R=2).
REQ-028 rounds_i=6 and then rounds_i=8, random state -> golden p6/p8 (constants starting at 8'h96 and 8'hB4); done at cycles 7 and 9.
REQ-029 rounds_i=0 -> done_o at cycle 1 with state_o==state_i; rounds_i=15 behaves identically to rounds_i=12.
REQ-030 start_i held high throughout -> back-to-back runs each of full latency, with no missing or extra done_o pulses.
REQ-031 rst_n_i low at cycle 5 of a p12 run -> state_o=0 and busy_o=0 at once, no done_o; a new run afterwards completes correctly.

Source files
------------

// File: rtl/ascon_perm_pkg.sv
// Shared types, constants and round primitives for the Ascon permutation.
// Pure combinational helpers; no latency or backpressure of their own.
package ascon_perm_pkg;

    localparam int MAX_ROUNDS = 12;

    // Lane x0 sits at index 0, x4 at index 4.
    typedef logic [4:0][63:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_t;

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return 8'hF0 - ({4'h0, idx} * 8'h0F);
    endfunction

    function automatic state_t sbox_layer(input state_t s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0] ^ s[4];
        x1 = s[1];
        x2 = s[2] ^ s[1];
        x3 = s[3];
        x4 = s[4] ^ s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int amt);
        return (x >> amt) | (x << (64 - amt));
    endfunction

    function automatic state_t linear_layer(input state_t s);
        state_t r;
        r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        r[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
        r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        r[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
        return r;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, S-box layer, linear layer.
// Purely combinational (0 cycles); no backpressure.
module ascon_round
    import ascon_perm_pkg::*;
(
    input  state_t     state_cur,
    input  logic [3:0] round_idx,
    output state_t     state_nxt
);

    state_t with_const;

    always_comb begin
        with_const    = state_cur;
        with_const[2] = state_cur[2] ^ {56'h0, round_const(round_idx)};
    end

    assign state_nxt = linear_layer(sbox_layer(with_const));

endmodule

// File: rtl/ascon_perm.sv
// Iterative Ascon permutation, ROUNDS_PER_CYCLE rounds per clock; optional intr_o via ASCON_PERM_INTR_EN.
// Latency ceil(n/R)+1 cycles to done_o; start_i is ignored while busy, nothing is queued.
module ascon_perm
    import ascon_perm_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [3:0] rounds_i,
    input  state_t     state_i,
    output state_t     state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       update_state_o
`ifdef ASCON_PERM_INTR_EN
    ,
    output logic       intr_o
`endif
);

    fsm_t       fsm;
    logic [3:0] round_idx;
    logic [3:0] remaining;
    logic [3:0] n_eff;
    logic [3:0] step;
    state_t     nxt_state;
    state_t     chain [ROUNDS_PER_CYCLE+1];

    assign chain[0] = state_o;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        ascon_round u_round (
            .state_cur (chain[g]),
            .round_idx (round_idx + 4'(g)),
            .state_nxt (chain[g+1])
        );
    end

    // Pick the tap after `step` rounds; later chain stages are don't-care on a short final cycle.
    always_comb begin
        n_eff = (rounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds_i;
        step  = (remaining < 4'(ROUNDS_PER_CYCLE)) ? remaining : 4'(ROUNDS_PER_CYCLE);
        nxt_state = chain[1];
        for (int k = 2; k <= ROUNDS_PER_CYCLE; k++) begin
            if (4'(k) <= remaining) nxt_state = chain[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm            <= ST_IDLE;
            state_o        <= '0;
            round_idx      <= '0;
            remaining      <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            update_state_o <= 1'b0;
`ifdef ASCON_PERM_INTR_EN
            intr_o         <= 1'b0;
`endif
        end else begin
            case (fsm)
                ST_IDLE: begin
                    done_o         <= 1'b0;
                    update_state_o <= 1'b0;
                    if (start_i) begin
                        state_o   <= state_i;
                        remaining <= n_eff;
                        round_idx <= 4'(MAX_ROUNDS) - n_eff;
                        busy_o    <= 1'b1;
`ifdef ASCON_PERM_INTR_EN
                        intr_o    <= (n_eff == 4'd0);
`endif
                        if (n_eff == 4'd0) begin
                            fsm            <= ST_DONE;
                            done_o         <= 1'b1;
                            update_state_o <= 1'b1;
                        end else begin
                            fsm <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    state_o   <= nxt_state;
                    round_idx <= round_idx + step;
                    remaining <= remaining - step;
                    if (remaining == step) begin
                        fsm            <= ST_DONE;
                        done_o         <= 1'b1;
                        update_state_o <= 1'b1;
`ifdef ASCON_PERM_INTR_EN
                        intr_o         <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    fsm            <= ST_IDLE;
                    busy_o         <= 1'b0;
                    done_o         <= 1'b0;
                    update_state_o <= 1'b0;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm.sv
// Directed bench for ascon_perm: R=1 and R=2 instances side by side against a
// column-table reference model of the Ascon round.
module tb_ascon_perm;
    import ascon_perm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start2;
    logic [3:0] rounds;
    state_t     st_in;
    state_t     st_o1, st_o2;
    logic       busy1, busy2, done1, done2, upd1, upd2;
`ifdef ASCON_PERM_INTR_EN
    logic       intr1, intr2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ascon_perm #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .rounds_i(rounds), .state_i(st_in),
        .state_o(st_o1), .busy_o(busy1), .done_o(done1), .update_state_o(upd1)
`ifdef ASCON_PERM_INTR_EN
        , .intr_o(intr1)
`endif
    );

    ascon_perm #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .rounds_i(rounds), .state_i(st_in),
        .state_o(st_o2), .busy_o(busy2), .done_o(done2), .update_state_o(upd2)
`ifdef ASCON_PERM_INTR_EN
        , .intr_o(intr2)
`endif
    );

    // Reference model: S-box as a 32-entry lookup per bit column (x0 is the MSB).
    function automatic logic [4:0] sbox5(input logic [4:0] v);
        logic [4:0] t [32];
        t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        return t[v];
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int a);
        logic [63:0] r;
        for (int j = 0; j < 64; j++) r[j] = x[(j + a) % 64];
        return r;
    endfunction

    function automatic state_t model_round(input state_t s_in, input int r);
        state_t s, o;
        logic [4:0] w;
        s = s_in;
        s[2][7:0] = s[2][7:0] ^ 8'(240 - 15 * r);
        for (int b = 0; b < 64; b++) begin
            w = sbox5({s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]});
            for (int j = 0; j < 5; j++) o[j][b] = w[4-j];
        end
        s = o;
        o[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
        o[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
        o[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
        o[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
        o[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
        return o;
    endfunction

    function automatic state_t model_perm(input state_t s_in, input int n);
        state_t s;
        int ne;
        s  = s_in;
        ne = (n > 12) ? 12 : n;
        for (int r = 12 - ne; r < 12; r++) s = model_round(s, r);
        return s;
    endfunction

    function automatic state_t rand_state();
        state_t r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
        return r;
    endfunction

    // Launches one run on both instances and observes 18 cycles; returns observations only.
    task automatic run_perm(input logic [3:0] n, input state_t s, input bit poke,
                            output int lat1, output int lat2,
                            output state_t res1, output state_t res2,
                            output state_t hold1, output state_t hold2, output int proto_bad);
        int p1, p2;
        lat1 = -1; lat2 = -1; res1 = '0; res2 = '0; proto_bad = 0; p1 = 0; p2 = 0;
        start1 = 1'b1; start2 = 1'b1; rounds = n; st_in = s;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(posedge clk); #1;
            start1 = poke && (cyc == 3 || cyc == 7);
            start2 = 1'b0;
            rounds = 4'($urandom());
            st_in  = rand_state();
            if (done1) begin p1++; if (lat1 < 0) begin lat1 = cyc; res1 = st_o1; end end
            if (done2) begin p2++; if (lat2 < 0) begin lat2 = cyc; res2 = st_o2; end end
            if (done1 !== upd1 || done2 !== upd2) proto_bad++;
            if (busy1 !== (lat1 < 0 || cyc == lat1)) proto_bad++;
            if (busy2 !== (lat2 < 0 || cyc == lat2)) proto_bad++;
`ifdef ASCON_PERM_INTR_EN
            if (intr1 !== (lat1 > 0) || intr2 !== (lat2 > 0)) proto_bad++;
`endif
        end
        if (p1 != 1 || p2 != 1) proto_bad++;
        hold1 = st_o1; hold2 = st_o2;
    endtask

    task automatic test_reset();
        vectors++;
        if (st_o1 !== '0 || st_o2 !== '0) begin
            miscompares++; $display("FAIL reset_state: got %h / %h want 0", st_o1, st_o2);
        end
        vectors++;
        if ({busy1, done1, upd1, busy2, done2, upd2} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000", {busy1, done1, upd1, busy2, done2, upd2});
        end
`ifdef ASCON_PERM_INTR_EN
        vectors++;
        if ({intr1, intr2} !== 2'b00) begin
            miscompares++; $display("FAIL reset_intr: got %b want 00", {intr1, intr2});
        end
`endif
    endtask

    task automatic test_full_run(input string name, input logic [3:0] n, input state_t s,
                                 input int want1, input int want2, input state_t exp);
        int lat1, lat2, bad;
        state_t r1, r2, h1, h2;
        run_perm(n, s, 1'b0, lat1, lat2, r1, r2, h1, h2, bad);
        vectors++;
        if (lat1 !== want1 || lat2 !== want2) begin
            miscompares++;
            $display("FAIL %s latency: got %0d/%0d want %0d/%0d", name, lat1, lat2, want1, want2);
        end
        vectors++;
        if (r1 !== exp) begin miscompares++; $display("FAIL %s r1_state: got %h want %h", name, r1, exp); end
        vectors++;
        if (r2 !== exp) begin miscompares++; $display("FAIL %s r2_state: got %h want %h", name, r2, exp); end
        vectors++;
        if (h1 !== exp || h2 !== exp) begin
            miscompares++; $display("FAIL %s hold: got %h / %h want %h", name, h1, h2, exp);
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL %s handshake: got %0d bad cycles want 0", name, bad); end
    endtask

    task automatic test_p12_zero();
        test_full_run("p12_zero", 4'd12, '0, 13, 7, model_perm('0, 12));
    endtask

    task automatic test_ascon_init();
        state_t s;
        s = '0;
        s[0] = 64'h80400C0600000000;
        test_full_run("ascon_init", 4'd12, s, 13, 7, model_perm(s, 12));
    endtask

    task automatic test_p6_p8();
        state_t s;
        s = rand_state();
        test_full_run("p6", 4'd6, s, 7, 4, model_perm(s, 6));
        s = rand_state();
        test_full_run("p8", 4'd8, s, 9, 5, model_perm(s, 8));
    endtask

    task automatic test_round_limits();
        state_t s;
        s = rand_state();
        test_full_run("n0", 4'd0, s, 1, 1, s);
        s = rand_state();
        test_full_run("n15", 4'd15, s, 13, 7, model_perm(s, 12));
    endtask

    task automatic test_start_ignored();
        int lat1, lat2, bad;
        state_t s, exp, r1, r2, h1, h2;
        s = rand_state();
        exp = model_perm(s, 6);
        run_perm(4'd6, s, 1'b1, lat1, lat2, r1, r2, h1, h2, bad);
        vectors++;
        if (lat1 !== 7) begin miscompares++; $display("FAIL ignore_latency: got %0d want 7", lat1); end
        vectors++;
        if (r1 !== exp || h1 !== exp) begin
            miscompares++; $display("FAIL ignore_state: got %h / %h want %h", r1, h1, exp);
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL ignore_handshake: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        state_t s, exp, last1, last2;
        int mask1, mask2;
        s = rand_state();
        exp = model_perm(s, 2);
        mask1 = 0; mask2 = 0; last1 = '0; last2 = '0;
        start1 = 1'b1; start2 = 1'b1; rounds = 4'd2; st_in = s;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (done1) begin mask1 = mask1 | (1 << cyc); last1 = st_o1; end
            if (done2) begin mask2 = mask2 | (1 << cyc); last2 = st_o2; end
        end
        start1 = 1'b0; start2 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (mask1 !== 32'h0888) begin miscompares++; $display("FAIL b2b_pulses_r1: got %h want 00000888", mask1); end
        vectors++;
        if (mask2 !== 32'h4924) begin miscompares++; $display("FAIL b2b_pulses_r2: got %h want 00004924", mask2); end
        vectors++;
        if (last1 !== exp || last2 !== exp) begin
            miscompares++; $display("FAIL b2b_state: got %h / %h want %h", last1, last2, exp);
        end
        vectors++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle: got busy %b%b want 00", busy1, busy2);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat1, lat2, bad;
        state_t s, exp, r1, r2, h1, h2;
        s = rand_state();
        start1 = 1'b1; start2 = 1'b1; rounds = 4'd12; st_in = s;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0; start2 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (st_o1 !== '0 || st_o2 !== '0) begin
            miscompares++; $display("FAIL midrst_state: got %h / %h want 0", st_o1, st_o2);
        end
        vectors++;
        if ({busy1, done1, upd1, busy2, done2, upd2} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrst_flags: got %b want 000000", {busy1, done1, upd1, busy2, done2, upd2});
        end
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done1 || done2 || busy1 || busy2) bad++;
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
        rst_n = 1'b1;
        s = rand_state();
        exp = model_perm(s, 12);
        run_perm(4'd12, s, 1'b0, lat1, lat2, r1, r2, h1, h2, bad);
        vectors++;
        if (lat1 !== 13 || lat2 !== 7) begin
            miscompares++; $display("FAIL midrst_rerun_latency: got %0d/%0d want 13/7", lat1, lat2);
        end
        vectors++;
        if (r1 !== exp || r2 !== exp) begin
            miscompares++; $display("FAIL midrst_rerun_state: got %h / %h want %h", r1, r2, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; rounds = '0; st_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_p12_zero();
        test_ascon_init();
        test_p6_p8();
        test_round_limits();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
